sequence_pattern_generator: RTL and testbench

SEQUENCE_PATTERN_GENERATOR -- requirements
Module: sequence_pattern_generator

---
 rtl/sequence_pattern_generator.sv | 190 +++++++++++++++++++
 tb/tb_sequence_pattern_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_pattern_generator.sv
// Purpose : serializes a captured pattern MSB-first for a programmable number of repetitions, with optional idle gaps between repetitions.
// Latency : first pattern bit appears on the cycle after the edge that samples start; done pulses one cycle after the last bit.
// Backpressure: none; once a burst starts it runs to completion, abort or reset, and start is ignored (not queued) while busy.
//
// Ports:
//   clock          - single clock, all state changes on the rising edge
//   reset          - synchronous active-high reset, overrides start and abort
//   start          - begin a burst; only looked at while idle
//   abort          - cancel the running burst (no done pulse); ignored while idle
//   pattern_in     - pattern to serialize, captured on start
//   repeat_count   - number of pattern repetitions, captured on start (0 = empty burst)
//   gap_len        - idle cycles between repetitions, captured on start
//   sequence_out   - serial pattern bit, 0 whenever no pattern bit is being sent
//   sequence_valid - high on cycles where sequence_out carries a pattern bit
//   busy           - high in every state except idle
//   done           - one-cycle pulse on normal burst completion

module sequence_pattern_generator #(
    parameter int PATTERN_WIDTH = 4,
    parameter int COUNT_WIDTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PATTERN_WIDTH-1:0] pattern_in,
    input  logic [COUNT_WIDTH-1:0]   repeat_count,
    input  logic [COUNT_WIDTH-1:0]   gap_len,
    output logic                     sequence_out,
    output logic                     sequence_valid,
    output logic                     busy,
    output logic                     done
);

    // A one-bit pattern still needs a one-bit index register.
    localparam int BIT_W = (PATTERN_WIDTH > 1) ? $clog2(PATTERN_WIDTH) : 1;
    localparam logic [BIT_W-1:0]       LAST_BIT = BIT_W'(PATTERN_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [BIT_W-1:0]       IDX_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q,   state_d;
    logic [PATTERN_WIDTH-1:0] pattern_q, pattern_d;
    logic [COUNT_WIDTH-1:0]   repeat_q,  repeat_d;
    logic [COUNT_WIDTH-1:0]   gap_q,     gap_d;
    logic [COUNT_WIDTH-1:0]   rep_cnt_q, rep_cnt_d;
    logic [COUNT_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;

    logic seq_out_q, seq_out_d;
    logic seq_vld_q, seq_vld_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;

    logic last_bit;
    logic last_rep;
    logic gap_end;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        repeat_d  = repeat_q;
        gap_d     = gap_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        bit_idx_d = bit_idx_q;

        last_bit  = (bit_idx_q == LAST_BIT);
        // rep_cnt_q counts completed repetitions, so the one in flight is
        // the last when it equals repeat_q-1 (repeat_q is never 0 in SHIFT).
        last_rep  = (rep_cnt_q == (repeat_q - CNT_ONE));
        // GAP is only entered with gap_q != 0, so gap_q-1 never wraps here.
        gap_end   = (gap_cnt_q == (gap_q - CNT_ONE));

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pattern_d = pattern_in;
                    repeat_d  = repeat_count;
                    gap_d     = gap_len;
                    rep_cnt_d = CNT_ZERO;
                    gap_cnt_d = CNT_ZERO;
                    bit_idx_d = '0;
                    state_d   = (repeat_count == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (last_bit) begin
                    bit_idx_d = '0;
                    if (last_rep) begin
                        state_d = ST_DONE;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                        if (gap_q != CNT_ZERO) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = CNT_ZERO;
                        end
                        // gap_q == 0: stay in SHIFT, wrapped index gives
                        // back-to-back repetitions.
                    end
                end else begin
                    bit_idx_d = bit_idx_q + IDX_ONE;
                end
            end

            ST_GAP: begin
                if (gap_end) begin
                    state_d   = ST_SHIFT;
                    gap_cnt_d = CNT_ZERO;
                    bit_idx_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything except reset, but only once a burst
        // is running; in IDLE a simultaneous start takes precedence.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so that they line up
    // with the state they describe (first bit one cycle after start).
    // ------------------------------------------------------------------
    always_comb begin
        seq_vld_d = (state_d == ST_SHIFT);
        seq_out_d = seq_vld_d & pattern_d[LAST_BIT - bit_idx_d];
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            repeat_q  <= '0;
            gap_q     <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            bit_idx_q <= '0;
            seq_out_q <= 1'b0;
            seq_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            repeat_q  <= repeat_d;
            gap_q     <= gap_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            bit_idx_q <= bit_idx_d;
            seq_out_q <= seq_out_d;
            seq_vld_q <= seq_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sequence_out   = seq_out_q;
    assign sequence_valid = seq_vld_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Purpose : scoreboard bench for sequence_pattern_generator, directed scenarios followed by random traffic.
// Latency : expected outputs are queued one per cycle when inputs are driven and compared one edge later.
// Backpressure: not applicable; the monitor consumes one expected entry per clock.

module tb_sequence_pattern_generator;

    localparam int PW = 4;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] pattern_in;
    logic [CW-1:0] repeat_count;
    logic [CW-1:0] gap_len;
    logic          sequence_out;
    logic          sequence_valid;
    logic          busy;
    logic          done;

    sequence_pattern_generator #(
        .PATTERN_WIDTH(PW),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .pattern_in    (pattern_in),
        .repeat_count  (repeat_count),
        .gap_len       (gap_len),
        .sequence_out  (sequence_out),
        .sequence_valid(sequence_valid),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected output word per cycle: {busy, done, valid, out}.
    logic [3:0] plan[$];   // remaining cycles of the burst in progress
    logic [3:0] expq[$];   // scoreboard: one entry per clock edge
    bit         cur_busy;
    int         n_vec;
    int         n_mis;

    // Reference model: a burst is a precomputed list of output cycles;
    // each clock either consumes the next entry, discards the list
    // (abort/reset) or builds a new list (start while idle).
    task automatic model(input logic rst, input logic st, input logic ab,
                         input logic [PW-1:0] pat, input logic [CW-1:0] rep,
                         input logic [CW-1:0] gap);
        logic [3:0] e;
        int nrep;
        int ngap;
        nrep = int'(rep);
        ngap = int'(gap);
        e = 4'b0000;
        if (rst) begin
            plan.delete();
        end else if (!cur_busy) begin
            if (st) begin
                plan.delete();
                for (int r = 0; r < nrep; r++) begin
                    for (int b = PW - 1; b >= 0; b--)
                        plan.push_back({1'b1, 1'b0, 1'b1, pat[b]});
                    if (r < nrep - 1)
                        for (int g = 0; g < ngap; g++)
                            plan.push_back(4'b1000);
                end
                plan.push_back(4'b1100);
                e = plan.pop_front();
            end
        end else if (ab) begin
            plan.delete();
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end
        cur_busy = e[3];
        expq.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and queue its expectation.
    task automatic step(input logic rst, input logic st, input logic ab,
                        input logic [PW-1:0] pat, input logic [CW-1:0] rep,
                        input logic [CW-1:0] gap);
        @(negedge clock);
        reset        = rst;
        start        = st;
        abort        = ab;
        pattern_in   = pat;
        repeat_count = rep;
        gap_len      = gap;
        model(rst, st, ab, pat, rep, gap);
    endtask

    // Idle cycles with scrambled data inputs, which must not disturb a burst.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, PW'($urandom), CW'($urandom), CW'($urandom));
    endtask

    // Monitor: compares DUT outputs shortly after every rising edge.
    initial begin
        logic [3:0] e;
        logic [3:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                act = {busy, done, sequence_valid, sequence_out};
                n_vec++;
                if (act !== e) begin
                    n_mis++;
                    $display("FAIL outputs t=%0t busy/done/valid/out got %b want %b",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        n_vec    = 0;
        n_mis    = 0;
        cur_busy = 1'b0;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        pattern_in   = '0;
        repeat_count = '0;
        gap_len      = '0;

        // Reset state, with start/abort high to show reset overrides them.
        step(1'b1, 1'b1, 1'b1, 4'b1011, 4'd1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'b1011, 4'd1, 4'd0);
        idle(2);

        // Single repetition 1011.
        step(1'b0, 1'b1, 1'b0, 4'b1011, 4'd1, 4'd0);
        idle(7);

        // Three back-to-back repetitions.
        step(1'b0, 1'b1, 1'b0, 4'b1011, 4'd3, 4'd0);
        idle(15);

        // Two repetitions of 1101 with a two-cycle gap.
        step(1'b0, 1'b1, 1'b0, 4'b1101, 4'd2, 4'd2);
        idle(13);

        // Empty burst.
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'd0, 4'd5);
        idle(3);

        // Start re-pulsed while busy is ignored; abort on the second bit.
        step(1'b0, 1'b1, 1'b0, 4'b1011, 4'd2, 4'd3);
        step(1'b0, 1'b1, 1'b0, 4'b0110, 4'd5, 4'd1);
        step(1'b0, 1'b0, 1'b1, 4'b0000, 4'd0, 4'd0);
        idle(4);

        // Abort together with start in idle: start wins.
        step(1'b0, 1'b1, 1'b1, 4'b1001, 4'd1, 4'd0);
        idle(6);

        // Reset during a gap, then a fresh burst.
        step(1'b0, 1'b1, 1'b0, 4'b1101, 4'd2, 4'd3);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0, 4'd0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 4'b1011, 4'd1, 4'd0);
        idle(6);

        // Abort during the done cycle suppresses nothing further but must go idle.
        step(1'b0, 1'b1, 1'b0, 4'b0101, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'b0000, 4'd0, 4'd0);
        idle(2);

        // Maximum repeat count with a gap.
        step(1'b0, 1'b1, 1'b0, 4'b1000, 4'd15, 4'd1);
        idle(80);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic r, s, a;
            logic [CW-1:0] rc, gl;
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 39) == 0);
            rc = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
            gl = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 3));
            step(r, s, a, PW'($urandom), rc, gl);
        end

        // Drain: let any burst finish and the scoreboard empty.
        idle(300);
        @(negedge clock);
        @(negedge clock);
        if (expq.size() != 0) begin
            n_mis++;
            $display("FAIL drain leftover expectations got %0d want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
